// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that shares one memory bus between port C and port D.
// Latches the granted request, forwards it to memory and returns data/ack, with a watchdog.
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_read,
  output logic          m_write,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          owner,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLast = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

  state_e        state_q, state_d;
  logic          owner_q, grant_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, c_rdata_q, d_rdata_q, ret_data;
  logic [CW-1:0] cnt_q;
  logic          m_read_q, m_read_d, m_write_q, m_write_d;
  logic          c_ack_q, c_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic          c_req, d_req, sel_write, abort, done;

  assign c_req = c_read | c_write;
  assign d_req = d_read | d_write;

  // Ties go to the port that did not own the bus last.
  always_comb begin
    grant_d = owner_q;
    if (c_req && d_req) grant_d = ~owner_q;
    else if (c_req)     grant_d = 1'b0;
    else if (d_req)     grant_d = 1'b1;
  end

  assign sel_write = grant_d ? d_write : c_write;
  // m_ack in the final watchdog cycle wins over the abort.
  assign abort    = (TIMEOUT != 0) && (state_q == StAccess) && (cnt_q == TLast) && !m_ack;
  assign done     = (state_q == StAccess) && (m_ack || abort);
  assign ret_data = m_ack ? m_rdata : '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (c_req || d_req) state_d = StAccess;
      StAccess:  if (done) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    m_read_d  = 1'b0;
    m_write_d = 1'b0;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c_req || d_req) begin
          m_write_d = sel_write;
          m_read_d  = !sel_write;
        end
      end
      StAccess: begin
        if (done) begin
          c_ack_d = !owner_q;
          d_ack_d = owner_q;
          err_d   = abort;
        end else begin
          m_read_d  = m_read_q;
          m_write_d = m_write_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      c_ack_q   <= c_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q   <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (state_q == StIdle && (c_req || d_req)) begin
      owner_q <= grant_d;
      addr_q  <= grant_d ? d_addr : c_addr;
      wdata_q <= grant_d ? d_wdata : c_wdata;
      cnt_q   <= '0;
    end else if (state_q == StAccess) begin
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        if (owner_q) d_rdata_q <= ret_data;
        else         c_rdata_q <= ret_data;
      end
    end
  end

  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign c_ack       = c_ack_q;
  assign d_ack       = d_ack_q;
  assign c_rdata     = c_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with the default watchdog, one with TIMEOUT=4.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c_read = 0, c_write = 0, d_read = 0, d_write = 0, m_ack = 0;
  logic [15:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [15:0] c_rdata, d_rdata, m_addr, m_wdata;
  logic        c_ack, d_ack, m_read, m_write, owner, busy, timeout_err;

  logic        w_c_read = 0, w_m_ack = 0, w_zero = 0;
  logic [15:0] w_c_addr = 0, w_m_rdata = 0, w_zero16 = 0;
  logic [15:0] w_c_rdata, w_d_rdata, w_m_addr, w_m_wdata;
  logic        w_c_ack, w_d_ack, w_m_read, w_m_write, w_owner, w_busy, w_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(4)) dut_wd (
    .clock(clock), .reset(reset),
    .c_read(w_c_read), .c_write(w_zero), .c_addr(w_c_addr), .c_wdata(w_zero16),
    .c_rdata(w_c_rdata), .c_ack(w_c_ack),
    .d_read(w_zero), .d_write(w_zero), .d_addr(w_zero16), .d_wdata(w_zero16),
    .d_rdata(w_d_rdata), .d_ack(w_d_ack),
    .m_read(w_m_read), .m_write(w_m_write), .m_addr(w_m_addr), .m_wdata(w_m_wdata),
    .m_rdata(w_m_rdata), .m_ack(w_m_ack),
    .owner(w_owner), .busy(w_busy), .timeout_err(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("assertion on %s", tag);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_mread", m_read, 0);
    chk("rst_mwrite", m_write, 0);
    chk("rst_cack", c_ack, 0);
    chk("rst_dack", d_ack, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_crdata", c_rdata, 0);
    tick();
    reset = 1'b1;
    tick();

    // Core read alone, memory acks one cycle after the first strobe cycle.
    c_read = 1; c_addr = 16'h0123;
    tick();
    chk("c1_busy", busy, 1);
    chk("c1_mread", m_read, 1);
    chk("c1_maddr", m_addr, 16'h0123);
    chk("c1_owner", owner, 0);
    tick();
    chk("c2_busy", busy, 1);
    chk("c2_mread", m_read, 1);
    chk("c2_cack", c_ack, 0);
    m_ack = 1; m_rdata = 16'hBEEF;
    tick();
    chk("c3_busy", busy, 1);
    chk("c3_cack", c_ack, 1);
    chk("c3_crdata", c_rdata, 16'hBEEF);
    chk("c3_dack", d_ack, 0);
    chk("c3_mread", m_read, 0);
    m_ack = 0; m_rdata = 16'h0000; c_read = 0;
    tick();
    chk("c4_busy", busy, 0);
    chk("c4_cack", c_ack, 0);
    chk("c4_dack", d_ack, 0);
    chk("c4_crdata_hold", c_rdata, 16'hBEEF);

    // Simultaneous requests from reset: C, D, C, D.
    do_reset();
    c_read = 1; c_addr = 16'h1111; d_read = 1; d_addr = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_owner", owner, i % 2);
      chk("rr_mread", m_read, 1);
      chk("rr_maddr", m_addr, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      m_ack = 1; m_rdata = 16'hA000 + 16'(i);
      tick();
      chk("rr_cack", c_ack, (i % 2 == 0) ? 1 : 0);
      chk("rr_dack", d_ack, (i % 2 == 1) ? 1 : 0);
      chk("rr_rdata", (i % 2 == 0) ? c_rdata : d_rdata, 16'hA000 + 16'(i));
      m_ack = 0;
      tick();
      chk("rr_idle", busy, 0);
    end
    c_read = 0; d_read = 0;
    tick();

    // Port D write with latency 5; address/data change during access must not leak.
    d_write = 1; d_addr = 16'h4000; d_wdata = 16'h5A5A;
    tick();
    for (int j = 1; j <= 5; j++) begin
      chk("dw_mwrite", m_write, 1);
      chk("dw_mread", m_read, 0);
      chk("dw_maddr", m_addr, 16'h4000);
      chk("dw_mwdata", m_wdata, 16'h5A5A);
      chk("dw_dack", d_ack, 0);
      if (j == 1) begin d_addr = 16'h7777; d_wdata = 16'h0000; end
      if (j == 5) begin m_ack = 1; m_rdata = 16'h0BAD; end
      tick();
    end
    chk("dw_ack", d_ack, 1);
    chk("dw_cack", c_ack, 0);
    chk("dw_mwrite_off", m_write, 0);
    m_ack = 0; d_write = 0;
    tick();
    chk("dw_idle", busy, 0);
    chk("dw_ack_off", d_ack, 0);

    // m_ack while idle is ignored.
    m_ack = 1; m_rdata = 16'h1357;
    tick();
    m_ack = 0;
    chk("stray_busy", busy, 0);
    chk("stray_cack", c_ack, 0);
    chk("stray_dack", d_ack, 0);

    // Reset pulled mid-access clears asynchronously.
    c_read = 1; c_addr = 16'h0AAA;
    tick();
    chk("ra_busy", busy, 1);
    chk("ra_mread", m_read, 1);
    #2 reset = 1'b0;
    #1;
    chk("ra_async_busy", busy, 0);
    chk("ra_async_mread", m_read, 0);
    chk("ra_async_cack", c_ack, 0);
    chk("ra_async_owner", owner, 1);
    tick();
    reset = 1'b1; c_read = 0;
    tick();
    chk("ra_no_ack", c_ack, 0);
    d_read = 1; d_addr = 16'h3333;
    tick();
    chk("ra_d_owner", owner, 1);
    chk("ra_d_maddr", m_addr, 16'h3333);
    m_ack = 1; m_rdata = 16'h1234;
    tick();
    chk("ra_d_ack", d_ack, 1);
    chk("ra_d_rdata", d_rdata, 16'h1234);
    chk("ra_d_cack", c_ack, 0);
    m_ack = 0; d_read = 0;
    tick();
    c_read = 1; c_addr = 16'h0C0C; d_read = 1; d_addr = 16'h0D0D;
    tick();
    chk("ra_tie_owner", owner, 0);
    chk("ra_tie_maddr", m_addr, 16'h0C0C);
    m_ack = 1; m_rdata = 16'h4321;
    tick();
    chk("ra_tie_cack", c_ack, 1);
    m_ack = 0; c_read = 0; d_read = 0;
    tick();

    // Watchdog abort with TIMEOUT=4.
    w_c_read = 1; w_c_addr = 16'h0055;
    tick();
    for (int j = 1; j <= 4; j++) begin
      chk("wd_mread", w_m_read, 1);
      chk("wd_err_early", w_err, 0);
      chk("wd_cack_early", w_c_ack, 0);
      tick();
    end
    chk("wd_mread_off", w_m_read, 0);
    chk("wd_cack", w_c_ack, 1);
    chk("wd_crdata", w_c_rdata, 16'hFFFF);
    chk("wd_err", w_err, 1);
    w_c_read = 0;
    tick();
    chk("wd_idle", w_busy, 0);
    chk("wd_err_off", w_err, 0);
    chk("wd_cack_off", w_c_ack, 0);

    // Ack in the last watchdog cycle wins.
    w_c_read = 1; w_c_addr = 16'h0066;
    tick();
    for (int j = 1; j <= 4; j++) begin
      chk("wa_mread", w_m_read, 1);
      if (j == 4) begin w_m_ack = 1; w_m_rdata = 16'h0F0F; end
      tick();
    end
    chk("wa_cack", w_c_ack, 1);
    chk("wa_crdata", w_c_rdata, 16'h0F0F);
    chk("wa_err", w_err, 0);
    w_m_ack = 0; w_c_read = 0;
    tick();
    chk("wa_idle", w_busy, 0);
    chk("wa_err_off", w_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port, round-robin arbiter that shares the single memory bus between the CPU core (port C) and a second bus master such as the frame/DMA engine (port D). It sits between the core's `mem_read`/`mem_write`/`mem_ack` handshake and the memory controller. It latches each granted request's address and data, forwards it to memory, and returns data and an ack to the owner. A per-access watchdog aborts accesses that memory never acknowledges.

## Interface
- `AW`, 16: address width.
- `DW`, 16: data width.
- `TIMEOUT`, 255: maximum cycles in ACCESS before abort; 0 disables the watchdog.

- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `c_read`, `c_write`  in  1  core request; held level until `c_ack`.
- `c_addr`  in  AW  core address.
- `c_wdata`  in  DW  core write data.
- `c_rdata`  out  DW  read data to core; valid while `c_ack`=1.
- `c_ack`  out  1  one-cycle completion pulse to core.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ack`: same as the `c_` ports, for port D.
- `m_read`, `m_write`  out  1  memory strobes, held until `m_ack` or abort.
- `m_addr`  out  AW  latched address.
- `m_wdata`  out  DW  latched write data.
- `m_rdata`  in  DW  memory read data; valid while `m_ack`=1.
- `m_ack`  in  1  memory completion, single-cycle pulse.
- `owner`  out  1  0 = C, 1 = D; port of the current or most recent grant.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse when an access is aborted.

## Operation
- Request per port: `x_req = x_read | x_write`. If both are high, the access is a write.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - One port requesting: grant it.
  - Both requesting: grant the port that is not `owner` (round-robin).
  - On grant: latch addr, wdata and direction; set `owner`; clear the watchdog counter; go to ACCESS.
- ACCESS:
  - `m_read`/`m_write` are registered and asserted for the whole state.
  - The watchdog counter increments each cycle.
  - Port requests are ignored.
- On `m_ack` in ACCESS:
  - Capture `m_rdata` (writes capture it too; the value is don't-care).
  - Next cycle: the owner's `x_ack`=1 with `x_rdata` equal to the captured value; go to RELEASE.
- Abort, when `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with no `m_ack`:
  - Drop the memory strobes.
  - Next cycle: owner's `x_ack`=1, `x_rdata`=all ones, `timeout_err`=1; go to RELEASE.
- `m_ack` and timeout in the same cycle: the ack wins; no error.
- RELEASE (exactly one cycle, the cycle the ack is visible):
  - Requests are ignored, so a request still high in the ack cycle is not re-granted.
  - Next state is IDLE.
- `m_ack` outside ACCESS is ignored.
- A requester that drops its request mid-access does not cancel the memory access; its ack is still produced.
- `x_rdata` holds its last value when the port's ack is low.
- Reset values: state IDLE; `owner`=1 (so C wins the first tie); all strobes, acks, `busy` and `timeout_err` = 0; latched addr, data and rdata = 0.
- Reset asserted mid-access: everything clears immediately and asynchronously. The in-flight access is abandoned and no ack is issued.

## Timing
- Request seen high at edge k: grant at k; `m_read`/`m_write` high during cycle k+1.
- `m_ack` in cycle k+L (L ≥ 1): `x_ack` in cycle k+L+1; IDLE again at cycle k+L+2.
- Minimum request-to-ack is 2 cycles. A new grant can occur at edge k+L+2, so the minimum period per access is 3 cycles.
- Abort: strobes are high for exactly `TIMEOUT` cycles; `x_ack` and `timeout_err` are high the cycle after.
- Port requirement: a requester must deassert, or present a new request, in the cycle after its ack.
- Only one of `c_ack`/`d_ack` is ever high in a given cycle.

## Test plan
- Core read alone:
  - Stimulus: `c_read`, `c_addr`=0x0123; memory acks 1 cycle after the strobe with 0xBEEF.
  - Required: `m_addr`=0x0123; `c_ack` pulses once with `c_rdata`=0xBEEF; `d_ack` never rises; `busy` is high exactly 3 cycles.
- Simultaneous requests, repeated:
  - Stimulus: C and D both request continuously for 4 accesses.
  - Required: grant order C, D, C, D from reset; each ack is returned to the matching port.
- Port D write:
  - Stimulus: `d_write`, `d_addr`=0x4000, `d_wdata`=0x5A5A; memory latency 5.
  - Required: `m_write`=1 for 5 cycles with the latched values, even if `d_addr` changes during ACCESS; then one `d_ack`.
- Watchdog:
  - Stimulus: `TIMEOUT`=4; memory never acks a core read.
  - Required: `m_read` high for 4 cycles; then `c_ack`=1, `c_rdata`=0xFFFF, `timeout_err`=1; IDLE next.
  - Repeat with `m_ack` on the 4th cycle: required normal data and no error.
- Reset mid-access:
  - Stimulus: `reset` pulled low while in ACCESS.
  - Required: strobes, `busy` and acks go 0 without waiting for a clock edge; after release, a D-only request is served normally; the next tie grants C first.
